// File: rtl/instr_sequencer_pkg.sv
// Shared definitions for the instruction sequencer: phase encodings,
// condition-code values and instruction field positions.
package instr_sequencer_pkg;

  typedef enum logic [1:0] {
    FETCH  = 2'b00,
    DECODE = 2'b01,
    EXEC   = 2'b10,
    WB     = 2'b11
  } state_t;

  localparam logic [3:0] COND_EQ = 4'h0;
  localparam logic [3:0] COND_NE = 4'h1;
  localparam logic [3:0] COND_CS = 4'h2;
  localparam logic [3:0] COND_CC = 4'h3;
  localparam logic [3:0] COND_MI = 4'h4;
  localparam logic [3:0] COND_PL = 4'h5;
  localparam logic [3:0] COND_VS = 4'h6;
  localparam logic [3:0] COND_VC = 4'h7;
  localparam logic [3:0] COND_HI = 4'h8;
  localparam logic [3:0] COND_LS = 4'h9;
  localparam logic [3:0] COND_GE = 4'hA;
  localparam logic [3:0] COND_LT = 4'hB;
  localparam logic [3:0] COND_GT = 4'hC;
  localparam logic [3:0] COND_LE = 4'hD;
  localparam logic [3:0] COND_AL = 4'hE;
  localparam logic [3:0] COND_NV = 4'hF;

  localparam int COND_MSB    = 31;
  localparam int COND_LSB    = 28;
  localparam int CLASS_MSB   = 27;
  localparam int CLASS_LSB   = 25;
  localparam int T_BIT       = 25;
  localparam int OP_MSB      = 24;
  localparam int OP_LSB      = 21;
  localparam int L_BIT       = 20;
  localparam int RN_MSB      = 19;
  localparam int RN_LSB      = 16;
  localparam int RD_MSB      = 15;
  localparam int RD_LSB      = 12;
  localparam int RM_MSB      = 3;
  localparam int RM_LSB      = 0;
  localparam int OPERAND_MSB = 11;
  localparam int OFFSET_MSB  = 23;

  localparam logic [2:0] BRANCH_CLASS = 3'b101;

endpackage

// File: rtl/instr_sequencer_cond_check.sv
// Condition-code evaluation: decides whether an instruction with the given
// cond field executes under the current N,Z,C,V flags.
module cond_check
  import instr_sequencer_pkg::*;
(
  input  logic [3:0] cond,
  input  logic [3:0] nzcv,
  output logic       exec_en
);

  logic n, z, c, v;
  assign {n, z, c, v} = nzcv;

  always_comb begin
    exec_en = 1'b0;
    case (cond)
      COND_EQ: exec_en = z;
      COND_NE: exec_en = !z;
      COND_CS: exec_en = c;
      COND_CC: exec_en = !c;
      COND_MI: exec_en = n;
      COND_PL: exec_en = !n;
      COND_VS: exec_en = v;
      COND_VC: exec_en = !v;
      COND_HI: exec_en = c && !z;
      COND_LS: exec_en = !c || z;
      COND_GE: exec_en = (n == v);
      COND_LT: exec_en = (n != v);
      COND_GT: exec_en = !z && (n == v);
      COND_LE: exec_en = z || (n != v);
      COND_AL: exec_en = 1'b1;
      COND_NV: exec_en = 1'b0;
      default: exec_en = 1'b0;
    endcase
  end

endmodule

// File: rtl/instr_sequencer.sv
// Four-phase instruction sequencer: fetches a word, decodes its fields,
// evaluates its condition and advances or branches the pc on writeback.
module instr_sequencer
  import instr_sequencer_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  output logic [31:0] imem_addr,
  output logic        imem_rd,
  input  logic [31:0] imem_data,
  input  logic        imem_valid,
  input  logic [3:0]  nzcv,
  input  logic        bf,
  input  logic [31:0] branchimm,
  output logic [1:0]  state,
  output logic [31:0] pc,
  output logic [31:0] instr,
  output logic [3:0]  cond,
  output logic [3:0]  op,
  output logic [3:0]  rn,
  output logic [3:0]  rd,
  output logic [3:0]  rm,
  output logic        b,
  output logic        l,
  output logic        t,
  output logic [23:0] offset,
  output logic [11:0] operand,
  output logic        exec_en
);

  state_t      st, st_next;
  logic [31:0] pc_next, instr_next;

  always_ff @(posedge clk) begin
    if (reset) begin
      st    <= FETCH;
      pc    <= '0;
      instr <= '0;
    end else begin
      st    <= st_next;
      pc    <= pc_next;
      instr <= instr_next;
    end
  end

  always_comb begin
    st_next    = st;
    pc_next    = pc;
    instr_next = instr;
    unique case (st)
      FETCH: begin
        if (imem_valid) begin
          instr_next = imem_data;
          st_next    = DECODE;
        end
      end
      DECODE: st_next = EXEC;
      EXEC:   st_next = WB;
      WB: begin
        st_next = FETCH;
        // Branch target is relative to pc + 8 (two words of pipeline lookahead).
        pc_next = (bf && exec_en) ? (pc + 32'd8 + branchimm) : (pc + 32'd4);
      end
    endcase
  end

  // Reset gates the request so a reset cycle spent in FETCH never fetches.
  assign imem_rd   = (st == FETCH) && !reset;
  assign imem_addr = pc;
  assign state     = st;

  assign cond    = instr[COND_MSB:COND_LSB];
  assign op      = instr[OP_MSB:OP_LSB];
  assign rn      = instr[RN_MSB:RN_LSB];
  assign rd      = instr[RD_MSB:RD_LSB];
  assign rm      = instr[RM_MSB:RM_LSB];
  assign operand = instr[OPERAND_MSB:0];
  assign offset  = instr[OFFSET_MSB:0];
  assign t       = instr[T_BIT];
  assign l       = instr[L_BIT];
  assign b       = (instr[CLASS_MSB:CLASS_LSB] == BRANCH_CLASS);

  cond_check u_cond_check (
    .cond    (cond),
    .nzcv    (nzcv),
    .exec_en (exec_en)
  );

endmodule

// File: tb/tb_instr_sequencer.sv
// Scoreboard bench for instr_sequencer: stimulus queues expected decode and
// next-pc results; a negedge monitor pops and compares them as phases occur.
module tb_instr_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] imem_addr;
  logic        imem_rd;
  logic [31:0] imem_data;
  logic        imem_valid;
  logic [3:0]  nzcv;
  logic        bf;
  logic [31:0] branchimm;
  logic [1:0]  state;
  logic [31:0] pc;
  logic [31:0] instr;
  logic [3:0]  cond, op, rn, rd, rm;
  logic        b, l, t;
  logic [23:0] offset;
  logic [11:0] operand;
  logic        exec_en;

  instr_sequencer dut (
    .clk        (clk),
    .reset      (reset),
    .imem_addr  (imem_addr),
    .imem_rd    (imem_rd),
    .imem_data  (imem_data),
    .imem_valid (imem_valid),
    .nzcv       (nzcv),
    .bf         (bf),
    .branchimm  (branchimm),
    .state      (state),
    .pc         (pc),
    .instr      (instr),
    .cond       (cond),
    .op         (op),
    .rn         (rn),
    .rd         (rd),
    .rm         (rm),
    .b          (b),
    .l          (l),
    .t          (t),
    .offset     (offset),
    .operand    (operand),
    .exec_en    (exec_en)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] instr;
    logic [3:0]  cond, op, rn, rd, rm;
    logic        t, l, b;
    logic [23:0] offset;
    logic [11:0] operand;
    logic        exec_en;
  } dec_t;

  dec_t        dec_q[$];
  logic [31:0] pc_q[$];
  int          checks = 0;
  int          errors = 0;
  logic [31:0] cur_pc = '0;
  logic [1:0]  prev_state = 2'b00;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  function automatic dec_t mk(input logic [31:0] i, input logic [3:0] c, input logic [3:0] o,
                              input logic [3:0] n, input logic [3:0] d, input logic [3:0] m,
                              input logic tt, input logic ll, input logic bb,
                              input logic [23:0] off, input logic [11:0] opnd, input logic ee);
    dec_t r;
    r.instr = i; r.cond = c; r.op = o; r.rn = n; r.rd = d; r.rm = m;
    r.t = tt; r.l = ll; r.b = bb; r.offset = off; r.operand = opnd; r.exec_en = ee;
    return r;
  endfunction

  // Monitor: a fresh DECODE presents the latched word; WB->FETCH presents the new pc.
  always @(negedge clk) begin
    if (state == 2'b01 && prev_state == 2'b00) begin
      if (dec_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL dec_q_underflow: got empty queue expected an entry");
      end else begin
        dec_t e;
        e = dec_q.pop_front();
        chk("dec_instr",   instr,   e.instr);
        chk("dec_cond",    cond,    e.cond);
        chk("dec_op",      op,      e.op);
        chk("dec_rn",      rn,      e.rn);
        chk("dec_rd",      rd,      e.rd);
        chk("dec_rm",      rm,      e.rm);
        chk("dec_t",       t,       e.t);
        chk("dec_l",       l,       e.l);
        chk("dec_b",       b,       e.b);
        chk("dec_offset",  offset,  e.offset);
        chk("dec_operand", operand, e.operand);
        chk("dec_exec_en", exec_en, e.exec_en);
      end
    end
    if (state == 2'b00 && prev_state == 2'b11) begin
      if (pc_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL pc_q_underflow: got empty queue expected an entry");
      end else begin
        chk("next_pc", pc, pc_q.pop_front());
      end
    end
    prev_state = state;
  end

  // Runs one instruction; entered and left just after a rising edge in FETCH.
  task automatic do_instr(input logic [31:0] data, input int unsigned wait_n,
                          input logic [3:0] flags, input logic bf_exec, input logic bf_wb,
                          input logic [31:0] bimm, input dec_t exp_dec,
                          input logic [31:0] exp_pc);
    nzcv = flags; branchimm = bimm; bf = 1'b0;
    imem_valid = 1'b0; imem_data = 32'hBAD0BAD0;
    chk("fetch_state", state, 32'd0);
    chk("fetch_rd", imem_rd, 32'd1);
    chk("fetch_addr", imem_addr, cur_pc);
    for (int unsigned i = 0; i < wait_n; i++) begin
      @(posedge clk); #1;
      chk("fetch_hold_state", state, 32'd0);
      chk("fetch_hold_rd", imem_rd, 32'd1);
    end
    imem_valid = 1'b1; imem_data = data;
    dec_q.push_back(exp_dec);
    pc_q.push_back(exp_pc);
    @(posedge clk); #1;
    chk("decode_state", state, 32'd1);
    chk("decode_rd", imem_rd, 32'd0);
    imem_data = 32'h12345678;
    @(posedge clk); #1;
    chk("exec_state", state, 32'd2);
    imem_valid = 1'b0; bf = bf_exec;
    @(posedge clk); #1;
    chk("wb_state", state, 32'd3);
    chk("wb_instr_hold", instr, data);
    chk("wb_pc_hold", pc, cur_pc);
    bf = bf_wb;
    @(posedge clk); #1;
    bf = 1'b0;
    chk("back_to_fetch", state, 32'd0);
    cur_pc = exp_pc;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b1; imem_valid = 1'b0; imem_data = '0;
    nzcv = '0; bf = 1'b0; branchimm = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_state", state, 32'd0);
    chk("rst_pc", pc, 32'd0);
    chk("rst_instr", instr, 32'd0);
    chk("rst_rd", imem_rd, 32'd0);
    chk("rst_cond", cond, 32'd0);
    chk("rst_exec_en", exec_en, 32'd0);
    reset = 1'b0;
    #1;
    chk("post_rst_rd", imem_rd, 32'd1);

    // Zero-wait fetch, no branch: 0 -> 4
    do_instr(32'hE1A00000, 0, 4'h0, 1'b0, 1'b0, 32'h0,
             mk(32'hE1A00000, 4'hE, 4'hD, 4'h0, 4'h0, 4'h0, 1'b0, 1'b0, 1'b0, 24'hA00000, 12'h000, 1'b1),
             32'h4);
    // Three-cycle wait, ADD r2,r1,r3
    do_instr(32'hE0812003, 3, 4'h0, 1'b0, 1'b0, 32'h0,
             mk(32'hE0812003, 4'hE, 4'h4, 4'h1, 4'h2, 4'h3, 1'b0, 1'b0, 1'b0, 24'h812003, 12'h003, 1'b1),
             32'h8);
    // Branch from 0x8 to 0x100
    do_instr(32'hEA00003C, 1, 4'h0, 1'b0, 1'b1, 32'h000000F0,
             mk(32'hEA00003C, 4'hE, 4'h0, 4'h0, 4'h0, 4'hC, 1'b1, 1'b0, 1'b1, 24'h00003C, 12'h03C, 1'b1),
             32'h100);
    // bf only in EXEC is ignored: 0x100 -> 0x104
    do_instr(32'hEA000002, 0, 4'h0, 1'b1, 1'b0, 32'h8,
             mk(32'hEA000002, 4'hE, 4'h0, 4'h0, 4'h0, 4'h2, 1'b1, 1'b0, 1'b1, 24'h000002, 12'h002, 1'b1),
             32'h104);
    // Negative offset back to 0x100
    do_instr(32'hEA000002, 0, 4'h0, 1'b0, 1'b1, 32'hFFFFFFF4,
             mk(32'hEA000002, 4'hE, 4'h0, 4'h0, 4'h0, 4'h2, 1'b1, 1'b0, 1'b1, 24'h000002, 12'h002, 1'b1),
             32'h100);
    // Branch taken in WB: 0x100 -> 0x110
    do_instr(32'hEA000002, 0, 4'h0, 1'b0, 1'b1, 32'h8,
             mk(32'hEA000002, 4'hE, 4'h0, 4'h0, 4'h0, 4'h2, 1'b1, 1'b0, 1'b1, 24'h000002, 12'h002, 1'b1),
             32'h110);
    // BEQ with Z=0 fails: 0x110 -> 0x114
    do_instr(32'h0A000002, 0, 4'h0, 1'b0, 1'b1, 32'h8,
             mk(32'h0A000002, 4'h0, 4'h0, 4'h0, 4'h0, 4'h2, 1'b1, 1'b0, 1'b1, 24'h000002, 12'h002, 1'b0),
             32'h114);
    // BNE with Z=0 taken: 0x114 -> 0x124
    do_instr(32'h1A000002, 0, 4'h0, 1'b0, 1'b1, 32'h8,
             mk(32'h1A000002, 4'h1, 4'h0, 4'h0, 4'h0, 4'h2, 1'b1, 1'b0, 1'b1, 24'h000002, 12'h002, 1'b1),
             32'h124);
    // BGT with N=1,V=0 fails: 0x124 -> 0x128
    do_instr(32'hCA000002, 0, 4'h8, 1'b0, 1'b1, 32'h8,
             mk(32'hCA000002, 4'hC, 4'h0, 4'h0, 4'h0, 4'h2, 1'b1, 1'b0, 1'b1, 24'h000002, 12'h002, 1'b0),
             32'h128);
    // cond 1111 never executes: 0x128 -> 0x12C
    do_instr(32'hFA000002, 0, 4'hF, 1'b0, 1'b1, 32'h8,
             mk(32'hFA000002, 4'hF, 4'h0, 4'h0, 4'h0, 4'h2, 1'b1, 1'b0, 1'b1, 24'h000002, 12'h002, 1'b0),
             32'h12C);
    // BGE with N=1,V=1 taken: 0x12C -> 0x13C
    do_instr(32'hAA000002, 2, 4'h9, 1'b0, 1'b1, 32'h8,
             mk(32'hAA000002, 4'hA, 4'h0, 4'h0, 4'h0, 4'h2, 1'b1, 1'b0, 1'b1, 24'h000002, 12'h002, 1'b1),
             32'h13C);
    // Branch to the top word: 0x13C -> 0xFFFFFFFC
    do_instr(32'hEA000002, 0, 4'h0, 1'b0, 1'b1, 32'hFFFFFEB8,
             mk(32'hEA000002, 4'hE, 4'h0, 4'h0, 4'h0, 4'h2, 1'b1, 1'b0, 1'b1, 24'h000002, 12'h002, 1'b1),
             32'hFFFFFFFC);
    // Sequential wrap-around: 0xFFFFFFFC -> 0
    do_instr(32'hE1A00000, 0, 4'h0, 1'b0, 1'b0, 32'h0,
             mk(32'hE1A00000, 4'hE, 4'hD, 4'h0, 4'h0, 4'h0, 1'b0, 1'b0, 1'b0, 24'hA00000, 12'h000, 1'b1),
             32'h0);
    do_instr(32'hE1A00000, 0, 4'h0, 1'b0, 1'b0, 32'h0,
             mk(32'hE1A00000, 4'hE, 4'hD, 4'h0, 4'h0, 4'h0, 1'b0, 1'b0, 1'b0, 24'hA00000, 12'h000, 1'b1),
             32'h4);

    // Reset during DECODE at pc 0x4 with late imem_valid and bf pending
    nzcv = 4'h0; imem_valid = 1'b1; imem_data = 32'hE0812003;
    dec_q.push_back(mk(32'hE0812003, 4'hE, 4'h4, 4'h1, 4'h2, 4'h3, 1'b0, 1'b0, 1'b0, 24'h812003, 12'h003, 1'b1));
    @(posedge clk); #1;
    chk("mid_decode_state", state, 32'd1);
    reset = 1'b1; imem_data = 32'hDEADBEEF; bf = 1'b1; branchimm = 32'h8;
    #1;
    chk("mid_rst_rd_decode", imem_rd, 32'd0);
    @(posedge clk); #1;
    chk("mid_rst_state", state, 32'd0);
    chk("mid_rst_pc", pc, 32'd0);
    chk("mid_rst_instr", instr, 32'd0);
    chk("mid_rst_rd_fetch", imem_rd, 32'd0);
    @(posedge clk); #1;
    chk("mid_rst_instr2", instr, 32'd0);
    chk("mid_rst_pc2", pc, 32'd0);
    reset = 1'b0; imem_valid = 1'b0; bf = 1'b0;
    #1;
    chk("mid_rst_release_rd", imem_rd, 32'd1);
    chk("mid_rst_release_addr", imem_addr, 32'd0);
    cur_pc = '0;

    repeat (2) @(posedge clk);
    #1;
    chk("dec_q_empty", dec_q.size(), 32'd0);
    chk("pc_q_empty", pc_q.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
